simon_crypt_ctrl: RTL
=====================

// Module: simon_crypt_ctrl
// PURPOSE
//  Sequencer for the SIMON core: owns the round counter, drives the key-expansion
//  engine (load, expand T round keys) and the round datapath (load block, T rounds).
//  Valid/ready handshakes on key input, data input and result output.
//  Replaces the free-running count/gated-clock control of the key-expansion engine.
//  The expansion engine and the round datapath become pure enable-driven slaves.
// PARAMETERS
//  N  16  word size in bits (block = 2N)
//  M  4   key words (2, 3 or 4)
//  T  32  rounds, i.e. round keys generated per key
//  C  5   count width; elaboration error if T > 2**C or T < 2
// PORTS
//  clk       in   1  single clock, all logic on posedge
//  R         in   1  synchronous reset, active-high
//  keyValid  in   1  new key present on key bus (bus itself goes direct to expander)
//  keyReady  out  1  controller accepts key this cycle
//  dataValid in   1  plaintext block present
//  dataReady out  1  controller accepts block this cycle
//  outReady  in   1  consumer accepts result
//  outValid  out  1  result valid on round datapath output
//  ldKey     out  1  1-cycle pulse: expander loads key words
//  expEn     out  1  expander advances one round key this cycle
//  ldData    out  1  1-cycle pulse: round datapath loads block
//  rndEn     out  1  round datapath performs one round this cycle
//  count     out  C  round index: key-table write addr in EXPAND, read addr in CRYPT
//  keyDone   out  1  full key schedule valid in expander table
// BEHAVIOUR
//  Reset: while R=1 next cycle state=IDLE, count=0; all outputs 0 (keyReady 0 in reset cycle).
//  States IDLE, LOAD, EXPAND, KEYED, CRYPT, OUT; all outputs decoded from registered state/count.
//  IDLE : keyReady=1, dataReady=0. keyValid -> LOAD.
//  LOAD : ldKey=1 for exactly this cycle, count<=0 -> EXPAND.
//  EXPAND: expEn=1 each cycle, count increments; when count==T-1 -> KEYED, count<=0.
//         Exactly T expEn cycles; keyValid/dataValid ignored (ready low).
//  KEYED: keyDone=1, dataReady=1; keyReady = ~dataValid (data has priority).
//         dataValid -> ldData=1 same cycle (accept cycle), -> CRYPT, count<=0.
//         keyValid & ~dataValid -> LOAD; keyDone drops next cycle (rekey).
//  CRYPT: rndEn=1 each cycle, count 0..T-1; when count==T-1 -> OUT. keyDone stays 1.
//  OUT  : outValid=1, held with count=T-1 until outReady; outReady -> KEYED.
//         outValid never drops without outReady.
//  Latency: key accept to keyDone = T+2 cycles; data accept to outValid = T+1 cycles.
//  Back-to-back: outReady and new dataValid in consecutive cycles; one idle cycle
//   (KEYED) between results, no combinational valid->ready paths except keyReady.
//  count: C bits, never exceeds T-1, no wrap; unused states -> IDLE (safe default).
//  Reset mid-EXPAND/CRYPT/OUT: abort, keyDone=0, key must be reloaded.
// STRUCTURE
//  simon_pkg: typedef enum logic [2:0] ctrl_state_t {IDLE,LOAD,EXPAND,KEYED,CRYPT,OUT};
//   function rounds(N,M) returning standard T; shared z-sequence constants.
//  One sub-module: simon_round_counter (C-bit, clr/en, last = (count==T-1)).
//  Controller: one always_ff for state+count, one always_comb for next state/outputs.
// TESTING
//  1 Reset then keyValid=1 at cycle 2 -> ldKey pulse cycle 3, expEn 32 cycles
//    count 0..31, keyDone=1 at cycle 36.
//  2 KEYED, dataValid pulse -> ldData same cycle, rndEn 32 cycles, outValid
//    33 cycles later; outReady held 0 for 5 cycles -> outValid stays 1, count=31.
//  3 KEYED, keyValid=dataValid=1 same cycle -> data accepted, keyReady=0,
//    key taken after OUT/outReady handshake.
//  4 Rekey in KEYED (keyValid only) -> keyDone=0 next cycle, new T-cycle
//    expansion, keyDone=1 again.
//  5 R=1 at CRYPT count=10 -> next cycle all outputs 0, state IDLE; dataValid ignored
//    until new key expanded.
//  6 Params N=32,M=3,T=42,C=6 -> 42 expEn and 42 rndEn cycles; T=70,C=6 fails elaboration.

Source files
------------

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : simon_pkg
//  Desc    : Shared types and constants for the SIMON core: controller state
//            encoding, standard round-count lookup and the z-sequences.
//  Rev     : 1.0  initial release
// ============================================================================
package simon_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    KEYED  = 3'd3,
    CRYPT  = 3'd4,
    OUT    = 3'd5
  } ctrl_state_t;

  // Key-schedule constant sequences z0..z4 (62 bits each, MSB used first)
  localparam logic [61:0] c_z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] c_z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] c_z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] c_z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] c_z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  // Standard round count for word size n and key-word count m; 0 = illegal pair
  function automatic int rounds(input int n, input int m);
    int r;
    r = 0;
    case (n)
      16: if (m == 4) r = 32;
      24: if (m == 3 || m == 4) r = 36;
      32: if (m == 3) r = 42; else if (m == 4) r = 44;
      48: if (m == 2) r = 52; else if (m == 3) r = 54;
      64: if (m == 2) r = 68; else if (m == 3) r = 69; else if (m == 4) r = 72;
      default: r = 0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/simon_round_counter.sv
`default_nettype none
// ============================================================================
//  Module  : simon_round_counter
//  Desc    : C-bit round index with clear/enable. Saturates at T-1 so the
//            index can never wrap; o_last flags the final round.
//  Rev     : 1.0  initial release
// ============================================================================
module simon_round_counter #(
  parameter int T = 32,
  parameter int C = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [C-1:0] o_count,
  output logic         o_last
);
  import simon_pkg::*;

  localparam logic [C-1:0] c_last = C'(T - 1);

  logic [C-1:0] r_count;

  // Round index register: clear wins over enable, hold once the last round is reached
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/simon_crypt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : simon_crypt_ctrl
//  Desc    : SIMON sequencer. Loads and expands the key schedule, then runs
//            T rounds per accepted block and holds the result until taken.
//            Expander and round datapath are pure enable-driven slaves.
//  Rev     : 1.0  initial release
// ============================================================================
module simon_crypt_ctrl #(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int C = 5
) (
  input  logic         clk,
  input  logic         R,
  input  logic         keyValid,
  output logic         keyReady,
  input  logic         dataValid,
  output logic         dataReady,
  input  logic         outReady,
  output logic         outValid,
  output logic         ldKey,
  output logic         expEn,
  output logic         ldData,
  output logic         rndEn,
  output logic [C-1:0] count,
  output logic         keyDone
);
  import simon_pkg::*;

  // Reject parameter sets the round index cannot address or SIMON does not define
  generate
    if (T > (1 << C) || T < 2) begin : g_bad_rounds
      $error("simon_crypt_ctrl: T=%0d does not fit a %0d-bit round index", T, C);
    end
    if (rounds(N, M) == 0) begin : g_bad_geometry
      $error("simon_crypt_ctrl: N=%0d M=%0d is not a SIMON configuration", N, M);
    end
  endgenerate

  ctrl_state_t  r_state;
  ctrl_state_t  w_next_state;
  logic         w_cnt_clr;
  logic         w_cnt_en;
  logic         w_last;
  logic [C-1:0] w_count;
  logic         w_run;

  simon_round_counter #(
    .T (T),
    .C (C)
  ) u_round_counter (
    .clk     (clk),
    .rst     (R),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_last  (w_last)
  );

  // State register; reset aborts any key or block in flight
  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and round-index control; data takes priority over a new key in KEYED
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (keyValid) w_next_state = LOAD;
      end
      LOAD: begin
        w_cnt_clr    = 1'b1;
        w_next_state = EXPAND;
      end
      EXPAND: begin
        if (w_last) begin
          w_cnt_clr    = 1'b1;
          w_next_state = KEYED;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      KEYED: begin
        w_cnt_clr = 1'b1;
        if (dataValid)     w_next_state = CRYPT;
        else if (keyValid) w_next_state = LOAD;
      end
      CRYPT: begin
        // Index stays at T-1 into OUT so it marks the finished round
        if (w_last) w_next_state = OUT;
        else        w_cnt_en     = 1'b1;
      end
      OUT: begin
        if (outReady) begin
          w_cnt_clr    = 1'b1;
          w_next_state = KEYED;
        end
      end
      default: begin
        w_cnt_clr    = 1'b1;
        w_next_state = IDLE;
      end
    endcase
  end

  // All outputs decode registered state and are forced low while reset is held
  assign w_run     = ~R;
  assign keyReady  = w_run & ((r_state == IDLE) | ((r_state == KEYED) & ~dataValid));
  assign dataReady = w_run & (r_state == KEYED);
  assign ldKey     = w_run & (r_state == LOAD);
  assign expEn     = w_run & (r_state == EXPAND);
  assign ldData    = w_run & (r_state == KEYED) & dataValid;
  assign rndEn     = w_run & (r_state == CRYPT);
  assign outValid  = w_run & (r_state == OUT);
  assign keyDone   = w_run & ((r_state == KEYED) | (r_state == CRYPT) | (r_state == OUT));
  assign count     = w_run ? w_count : '0;

endmodule
`default_nettype wire
